// File: rtl/react_multi_timer.sv
// N-player reaction-time core: random pre-delay, go-lamp, per-channel BCD ms capture.
// Optional per-channel best-time registers are enabled with `define REACT_BEST_EN.
module react_multi_timer #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int N_CH         = 2,
  parameter int DELAY_MIN_MS = 1000,
  parameter int DELAY_MASK   = 2047,
  parameter int MAX_MS       = 9999
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_CH-1:0]      btn,
  input  logic [2:0]           sel,
  output logic                 led,
  output logic                 busy,
  output logic                 done,
  output logic [N_CH-1:0]      false_start,
  output logic [16*N_CH-1:0]   times,
  output logic [15:0]          disp,
  output logic [16*N_CH-1:0]   best
);

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (r[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = r[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  localparam int          PRESC_MAX = CLK_HZ / 1000 - 1;
  localparam int          PW        = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
  localparam logic [15:0] MAX_BCD   = to_bcd(MAX_MS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ARMED, S_DONE} state_t;

  state_t            state_reg;
  logic [PW-1:0]     presc_reg;
  logic [15:0]       lfsr_reg;
  logic [2:0]        start_sync_reg;
  logic [N_CH-1:0]   btn_meta_reg, btn_sync_reg, btn_prev_reg;
  logic [N_CH-1:0]   fs_reg, cap_reg;
  logic [31:0]       delay_reg, dcnt_reg;
  logic [15:0]       bcd_reg;
  logic [15:0]       times_reg [N_CH];
  logic              best_upd_reg;

  logic              tick, start_edge;
  logic [N_CH-1:0]   btn_edge;

  assign tick       = (presc_reg == PW'(PRESC_MAX));
  assign start_edge = start_sync_reg[1] & ~start_sync_reg[2];
  assign btn_edge   = btn_sync_reg & ~btn_prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg      <= '0;
      lfsr_reg       <= 16'hACE1;
      start_sync_reg <= '0;
      btn_meta_reg   <= '0;
      btn_sync_reg   <= '0;
      btn_prev_reg   <= '0;
    end else begin
      presc_reg      <= tick ? '0 : presc_reg + PW'(1);
      lfsr_reg       <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
      start_sync_reg <= {start_sync_reg[1:0], start};
      btn_meta_reg   <= btn;
      btn_sync_reg   <= btn_meta_reg;
      btn_prev_reg   <= btn_sync_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      fs_reg       <= '0;
      cap_reg      <= '0;
      delay_reg    <= '0;
      dcnt_reg     <= '0;
      bcd_reg      <= '0;
      best_upd_reg <= 1'b0;
      for (int k = 0; k < N_CH; k++) times_reg[k] <= MAX_BCD;
    end else begin
      best_upd_reg <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start_edge) begin
            state_reg <= S_WAIT;
            delay_reg <= 32'(DELAY_MIN_MS) + {16'd0, lfsr_reg & 16'(DELAY_MASK)};
            dcnt_reg  <= '0;
            fs_reg    <= '0;
            cap_reg   <= '0;
            bcd_reg   <= '0;
            for (int k = 0; k < N_CH; k++) times_reg[k] <= MAX_BCD;
          end
        end
        S_WAIT: begin
          fs_reg  <= fs_reg | btn_edge;
          cap_reg <= cap_reg | btn_edge;
          // A field of all false starts skips ARMED so the lamp never lights.
          if (&(cap_reg | btn_edge)) begin
            state_reg <= S_DONE;
          end else if (tick) begin
            if (dcnt_reg == delay_reg - 32'd1) begin
              state_reg <= S_ARMED;
              bcd_reg   <= '0;
            end else begin
              dcnt_reg <= dcnt_reg + 32'd1;
            end
          end
        end
        S_ARMED: begin
          for (int k = 0; k < N_CH; k++)
            if (btn_edge[k] && !cap_reg[k]) times_reg[k] <= bcd_reg;
          cap_reg <= cap_reg | btn_edge;
          if (&(cap_reg | btn_edge)) begin
            state_reg    <= S_DONE;
            best_upd_reg <= 1'b1;
          end else if (tick) begin
            bcd_reg <= bcd_inc(bcd_reg);
            if (bcd_inc(bcd_reg) == MAX_BCD) begin
              state_reg    <= S_DONE;
              best_upd_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign led         = (state_reg == S_ARMED);
  assign busy        = (state_reg == S_WAIT) || (state_reg == S_ARMED);
  assign done        = (state_reg == S_DONE);
  assign false_start = fs_reg;

  always_comb begin
    disp = 16'hFFFF;
    for (int k = 0; k < N_CH; k++)
      if (sel == 3'(k)) disp = times_reg[k];
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign times[16*gi +: 16] = times_reg[gi];
`ifdef REACT_BEST_EN
    logic [15:0] best_reg;
    // Updated the cycle after leaving ARMED so a capture on the exit cycle is included.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        best_reg <= MAX_BCD;
      end else if (best_upd_reg && cap_reg[gi] && !fs_reg[gi] && (times_reg[gi] < best_reg)) begin
        best_reg <= times_reg[gi];
      end
    end
    assign best[16*gi +: 16] = best_reg;
`else
    assign best[16*gi +: 16] = MAX_BCD;
`endif
  end

`ifndef REACT_BEST_EN
  logic unused_best;
  assign unused_best = best_upd_reg;
`endif

endmodule

// File: tb/tb_react_multi_timer.sv
// Directed bench for react_multi_timer: scoreboard of per-round expected results.
module tb_react_multi_timer;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  btn;
  logic [2:0]  sel;
  logic        led, busy, done;
  logic [1:0]  false_start;
  logic [31:0] times, best;
  logic [15:0] disp;

  always #5 clk = ~clk;

  react_multi_timer #(
    .CLK_HZ(10_000), .N_CH(2), .DELAY_MIN_MS(5), .DELAY_MASK(3), .MAX_MS(50)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .btn(btn), .sel(sel),
    .led(led), .busy(busy), .done(done), .false_start(false_start),
    .times(times), .disp(disp), .best(best)
  );

  typedef struct {
    string       tag;
    logic [31:0] times;
    logic [1:0]  fs;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_best = 32'h0050_0050;
  int          cyc, led_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] best_model(input logic [31:0] cur, input logic [31:0] t,
                                             input logic [1:0] m);
    logic [31:0] r;
    r = cur;
`ifdef REACT_BEST_EN
    for (int k = 0; k < 2; k++)
      if (m[k] && t[16*k +: 16] < r[16*k +: 16]) r[16*k +: 16] = t[16*k +: 16];
`endif
    return r;
  endfunction

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic press(input logic [1:0] b);
    btn = b;
    repeat (4) @(negedge clk);
    btn = 2'b00;
  endtask

  task automatic wait_led(output int n);
    n = 0;
    while (!led && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("led_rise", 32'(led), 32'd1);
  endtask

  task automatic wait_done(output int lc);
    int n;
    n  = 0;
    lc = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
      if (led) lc++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic score;
    exp_t e;
    check("sb_size", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, "_times"}, times, e.times);
      check({e.tag, "_fs"}, 32'(false_start), 32'(e.fs));
      check({e.tag, "_led"}, 32'(led), 32'd0);
      check({e.tag, "_busy"}, 32'(busy), 32'd0);
      check({e.tag, "_best"}, best, exp_best);
      $display("round %s: times=%h false_start=%b best=%h", e.tag, times, false_start, best);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; btn = 2'b00; sel = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("rst_led", 32'(led), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fs", 32'(false_start), 32'd0);
    check("rst_times", times, 32'h0050_0050);
    check("rst_disp", 32'(disp), 32'h0050);
    check("rst_best", best, 32'h0050_0050);
    $display("reset: times=%h disp=%h", times, disp);

    // Round A: btn1 at 7 ms, btn0 at 23 ms after lamp.
    sb.push_back('{"A", 32'h0007_0023, 2'b00});
    exp_best = best_model(exp_best, 32'h0007_0023, 2'b11);
    pulse_start();
    wait_led(cyc);
    check("A_delay_in_range", 32'(cyc >= 35 && cyc <= 95), 32'd1);
    check("A_busy_armed", 32'(busy), 32'd1);
    repeat (70) @(negedge clk);
    press(2'b10);
    repeat (156) @(negedge clk);
    press(2'b01);
    wait_done(led_cyc);
    score();
    sel = 3'd1; #1;
    check("disp_sel1", 32'(disp), 32'h0007);
    sel = 3'd5; #1;
    check("disp_sel5", 32'(disp), 32'hFFFF);
    sel = 3'd0; #1;
    check("disp_sel0", 32'(disp), 32'h0023);

    // Round B: btn1 false start, btn0 at 12 ms.
    sb.push_back('{"B", 32'h0050_0012, 2'b10});
    exp_best = best_model(exp_best, 32'h0050_0012, 2'b01);
    pulse_start();
    repeat (10) @(negedge clk);
    check("B_busy_wait", 32'(busy), 32'd1);
    press(2'b10);
    check("B_fs_live", 32'(false_start), 32'b10);
    wait_led(cyc);
    repeat (120 - 1) @(negedge clk);
    @(negedge clk);
    press(2'b01);
    wait_done(led_cyc);
    score();

    // Round C: no presses, timeout after 50 ms lamp time.
    sb.push_back('{"C", 32'h0050_0050, 2'b00});
    pulse_start();
    wait_led(cyc);
    wait_done(led_cyc);
    check("C_led_ms", 32'(led_cyc + 1), 32'd500);
    score();

    // Round D: both players false start; lamp must stay dark.
    sb.push_back('{"D", 32'h0050_0050, 2'b11});
    pulse_start();
    repeat (10) @(negedge clk);
    press(2'b11);
    wait_done(led_cyc);
    check("D_led_never", 32'(led_cyc), 32'd0);
    score();

    // Round E: reset in the middle of ARMED.
    pulse_start();
    wait_led(cyc);
    press(2'b01);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    check("E_rst_led", 32'(led), 32'd0);
    check("E_rst_busy", 32'(busy), 32'd0);
    check("E_rst_times", times, 32'h0050_0050);
    exp_best = 32'h0050_0050;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("E_rst_best", best, exp_best);
    check("E_rst_done", 32'(done), 32'd0);
    $display("round E: reset mid-armed, times=%h led=%b", times, led);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
